// File: rtl/subtrator_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : FSM states IDLE / SHIFT / DONE
//   DEFAULT_WIDTH  : default operand/result width in bits
//   sub_ovf()      : two's-complement overflow of a - b from the sign bits
package subtrator_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Overflow of a - b: the operands have different signs and the result
  // sign differs from the minuend sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/subtrator_serial_if.sv
// Request/result bundle of the bit-serial subtractor.
//   start, a, b, bin              : request side (master drives)
//   busy, done, diff, bout, ovf,
//   zero                          : result side (slave drives)
interface subtrator_serial_if
  import subtrator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf, zero
  );

endinterface

// File: rtl/subtrator_serial_bit.sv
// One-bit full subtractor cell: d = x - y - br_in, with borrow out.
//   x, y   : operand bits
//   br_in  : incoming borrow
//   d      : difference bit
//   br_out : outgoing borrow
module subtracao_bit (
  input  logic x,
  input  logic y,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = x ^ y ^ br_in;
  assign br_out = (~x & y) | (~(x ^ y) & br_in);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell. A request is accepted in IDLE, the
// WIDTH bits are processed in SHIFT, and the registered results are
// published with a one-cycle done pulse in DONE.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of subtrator_serial_if
//           start/a/b/bin in; busy/done/diff/bout/ovf/zero out
module subtrator_serial
  import subtrator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  subtrator_serial_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               br_q;
  logic               a_msb_q, b_msb_q;
  // Holds the WIDTH-1 result bits produced so far; the newest bit is
  // prepended combinationally, so res_d is the full result on the last edge.
  logic [WIDTH-2:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q, ovf_q, zero_q;
  logic               cell_d, cell_br;
  logic               last_bit;

  subtracao_bit u_cell (
    .x      (a_q[0]),
    .y      (b_q[0]),
    .br_in  (br_q),
    .d      (cell_d),
    .br_out (cell_br)
  );

  assign res_d    = {cell_d, res_q};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            br_q    <= bus.bin;
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= cell_br;
          res_q <= res_d[WIDTH-1:1];
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            diff_q <= res_d;
            bout_q <= cell_br;
            ovf_q  <= sub_ovf(a_msb_q, b_msb_q, res_d[WIDTH-1]);
            zero_q <= (res_d == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed testbench for subtrator_serial (WIDTH = 8).
module tb_subtrator_serial;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   done_seen;

  subtrator_serial_if #(.WIDTH(W)) bus ();

  subtrator_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Waits after the accepting edge for done; lat = edges until done seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] d,
                              input logic bo, input logic ov, input logic z);
    check({name, ".diff"}, 64'(bus.diff), 64'(d));
    check({name, ".bout"}, 64'(bus.bout), 64'(bo));
    check({name, ".ovf"},  64'(bus.ovf),  64'(ov));
    check({name, ".zero"}, 64'(bus.zero), 64'(z));
  endtask

  // Drives a request, scrambles the inputs after acceptance and waits for done.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input string name);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb; bus.bin = tbin;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~ta; bus.b = ~tb; bus.bin = ~tbin;
    check({name, ".busy"}, 64'(bus.busy), 64'd1);
  endtask

  initial begin
    int lat;
    int d0;
    int first_e;
    int second_e;

    n_checks = 0; n_pass = 0; done_seen = 0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h2A, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check_result("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin, nm);
      wait_done(lat);
      check({nm, ".latency"}, 64'(lat), 64'(W));
      check({nm, ".busy_in_done"}, 64'(bus.busy), 64'd0);
      check_result(nm, vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero);
      @(posedge clk); #1;
      check({nm, ".done_one_cycle"}, 64'(bus.done), 64'd0);
      check({nm, ".hold_diff"}, 64'(bus.diff), 64'(vecs[i].diff));
    end

    // start pulsed during SHIFT must be ignored
    d0 = done_seen;
    start_op(8'h55, 8'h11, 1'b0, "ign");
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00; bus.bin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    check("ign.latency", 64'(lat), 64'(W - 3));
    check_result("ign", 8'h44, 1'b0, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    check("ign.done_pulses", 64'(done_seen - d0), 64'd1);
    check("ign.idle", 64'(bus.busy), 64'd0);

    // start held high: one result every W+2 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h40; bus.b = 8'h01; bus.bin = 1'b0;
    @(posedge clk); #1;
    first_e = -1; second_e = -1;
    for (int e = 1; e <= 30 && second_e < 0; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        if (first_e < 0) first_e = e;
        else second_e = e;
      end
    end
    bus.start = 1'b0;
    check("thr.first", 64'(first_e), 64'(W));
    check("thr.period", 64'(second_e - first_e), 64'(W + 2));
    check_result("thr", 8'h3F, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of SHIFT aborts without done
    start_op(8'h80, 8'h01, 1'b0, "abort");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    d0 = done_seen;
    #1;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check_result("abort", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort.no_done", 64'(done_seen - d0), 64'd0);
    bus.start = 1'b1; bus.a = 8'h09; bus.b = 8'h0C; bus.bin = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("post_rst.accept", 64'(bus.busy), 64'd1);
    wait_done(lat);
    check("post_rst.latency", 64'(lat), 64'(W));
    check_result("post_rst", 8'hFD, 1'b1, 1'b0, 1'b0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/subtrator_serial.md
SUBTRATOR_SERIAL -- requirements
Module: subtrator_serial

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request; SHALL be sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; SHALL be captured on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; SHALL be captured on the accepting edge.
REQ-007 bin  input  1  borrow-in for multi-word chaining; SHALL be captured on the accepting edge.
REQ-008 busy  output  1  high while a subtraction is in progress (SHIFT state).
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  final borrow-out (1 when a < b + bin, unsigned).
REQ-012 ovf  output  1  two's-complement overflow of the subtraction.
REQ-013 zero  output  1  high when diff == 0.

Function
REQ-014 FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-015 IDLE with start=1 at a rising edge SHALL load a, b and bin into internal registers, clear the bit counter, and go to SHIFT.
REQ-016 IDLE with start=0 SHALL remain in IDLE.
REQ-017 Each SHIFT edge SHALL process exactly one bit, LSB first, through a single 1-bit full-subtractor cell:
  - d = x^y^br
  - br_next = (~x&y) | (~(x^y)&br)
REQ-018 The borrow register SHALL feed the next bit; the result bit SHALL be shifted into diff from the MSB side.
REQ-019 After the WIDTH-th SHIFT edge, the FSM SHALL enter DONE; done SHALL rise on the WIDTH-th rising edge after the accepting edge.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-021 done SHALL be high only in DONE; busy SHALL be high only in SHIFT.
REQ-022 On the DONE transition:
  - bout SHALL take the final borrow.
  - ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - zero SHALL equal (diff == 0).
REQ-023 diff, bout, ovf and zero SHALL hold their values from DONE until the next DONE; they are don't-care during SHIFT.
REQ-024 start asserted during SHIFT or DONE SHALL be ignored; no queuing.
REQ-025 start held high continuously SHALL start a new operation on the first IDLE edge after DONE (throughput = one result per WIDTH+2 cycles).
REQ-026 Changes on a, b or bin after the accepting edge SHALL NOT affect the result in progress.
REQ-027 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-028 rst_n low SHALL immediately force:
  - state IDLE
  - counter 0
  - busy=0, done=0
  - diff=0, bout=0, ovf=0, zero=0
REQ-029 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-030 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-031 A shared package subtrator_pkg SHALL hold:
  - the state enum (IDLE, SHIFT, DONE)
  - the default WIDTH constant
REQ-032 The 1-bit cell SHALL be a separate sub-module subtracao_bit (x, y, br_in -> d, br_out), instantiated once.
REQ-033 No combinational path SHALL exist from any input to any output.

Verification (WIDTH=8)
REQ-034 a=5, b=3, bin=0, start one cycle -> done after 8 edges; diff=0x02, bout=0, ovf=0, zero=0.
REQ-035 a=3, b=5, bin=0 -> diff=0xFE, bout=1, ovf=0, zero=0.
REQ-036 a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-037 a=0x2A, b=0x2A, bin=0 -> diff=0x00, zero=1, bout=0.
REQ-038 start pulsed again at SHIFT cycle 3 with different operands -> ignored; first result intact; exactly one done pulse.
REQ-039 rst_n low at SHIFT cycle 4 -> busy and all outputs 0 immediately, no done; new start after release -> correct result.
